grf_sb: RTL
===========

Name: grf_sb

Overview:
- Parametrised general register file with integrated write-pending scoreboard for the pipelined CPU.
- Supports 2 combinational read ports and 1 write-back port, with same-cycle write-to-read bypass.
- Tracks in-flight writes per register via saturating pending counters, so the hazard unit can stall on busy operands.
- After reset, a sequential init engine clears storage one entry per cycle, so the array can map to RAM.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- CNT_W, 2, pending-counter width; max in-flight writes per register = 2**CNT_W-1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  clear all pending counters (pipeline flush).
- ready  out  1  high when init complete and file usable.
- ra1  in  ADDR_W  read address port 1.
- ra2  in  ADDR_W  read address port 2.
- rd1  out  DATA_W  read data port 1.
- rd2  out  DATA_W  read data port 2.
- busy1  out  1  ra1 has outstanding write.
- busy2  out  1  ra2 has outstanding write.
- iss_en  in  1  instruction issuing with destination iss_addr.
- iss_addr  in  ADDR_W  destination being reserved.
- iss_full  out  1  counter of iss_addr saturated; issue must stall.
- wb_en  in  1  write-back strobe.
- wb_addr  in  ADDR_W  write-back destination.
- wb_data  in  DATA_W  write-back data.
- wb_pc  in  32  PC of writing instruction (trace only).

Behaviour:
- State machine INIT / RUN.
  - reset (any state, any cycle) -> INIT, init pointer = 0, all counters = 0, ready = 0.
  - In INIT: entry[ptr] <= 0 each cycle, ptr++; after entry DEPTH-1 is cleared -> RUN next cycle.
  - ready = 1 only in RUN. INIT therefore lasts exactly DEPTH cycles after reset deasserts.
- While in INIT: rd1/rd2 = 0, busy1/busy2 = 0, iss_full = 0; iss_en, wb_en and flush are ignored.
- Address 0:
  - Never written; its counter is never incremented.
  - rd = 0, busy = 0, iss_full = 0 for address 0.
- Write (RUN, wb_en, wb_addr != 0): entry[wb_addr] <= wb_data at posedge.
- Read is combinational:
  - rdN = wb_data when wb_en && wb_addr == raN && raN != 0 (bypass).
  - Otherwise rdN = entry[raN].
- Counters (RUN), per register:
  - iss_en && !iss_full -> +1.
  - wb_en -> -1, but never below 0; a write-back at count 0 still writes data.
  - Issue and write-back to the same register in the same cycle -> counter unchanged.
  - Issue while iss_full -> ignored; no wrap-around.
  - flush -> all counters = 0. flush has priority over a same-cycle issue; a same-cycle write-back still writes data.
- busyN = (cnt[raN] != 0) && !(wb_en && wb_addr == raN && cnt[raN] == 1). The final outstanding write is visible through bypass, so busyN is not asserted for it.
- iss_full = (cnt[iss_addr] == 2**CNT_W-1).
- Reset values: ready = 0, rd1 = rd2 = 0, busy1 = busy2 = 0, iss_full = 0.

Optional Feature:
- GRF_SB_TRACE_EN defined:
  - On every RUN-state write-back with wb_en, display "@%h: $%d <= %h" with wb_pc, wb_addr, wb_data.
  - This includes wb_addr = 0, although the write itself is discarded.
- Undefined: no display statements are compiled; functionality is identical.

Test Plan:
- Reset held 2 cycles, then released -> ready = 0 for exactly 32 cycles, then 1; every ra1 reads 0 throughout.
- RUN, wb_en to addr 5 with 0x12345678, ra1 = 5 in the same cycle -> rd1 = 0x12345678 combinationally; next cycle with wb_en = 0, rd1 is still 0x12345678.
- iss_en to addr 3 three times -> iss_full = 1 with iss_addr = 3; a fourth issue is ignored. Three write-backs to addr 3 follow, each with ra2 = 3: busy2 = 1, 1, 0 (last one bypassed); after them busy2 = 0.
- Same cycle: iss_en to addr 7 plus wb_en to addr 7 with count 1 -> count stays 1, data written, busy1 (ra1 = 7) stays 1 next cycle.
- wb_en to addr 0 with 0xFFFFFFFF, ra1 = 0 -> rd1 = 0, busy1 = 0; trace line printed only with GRF_SB_TRACE_EN.
- Counters at 2 on addrs 4 and 9, then flush with iss_en on addr 4 -> both counters 0, busy deasserted. Reset asserted mid-INIT at pointer 10 -> pointer restarts at 0, ready stays low for a full 32 cycles.

Source files
------------

// File: rtl/grf_sb.sv
// General register file with per-register write-pending scoreboard and a
// sequential clear-after-reset engine. Define GRF_SB_TRACE_EN for a write-back trace.
module grf_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    output logic              ready,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_full,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [31:0]       wb_pc
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              run;

    assign run   = (state_reg == RUN);
    assign ready = run;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        if (state_reg == INIT) begin
            ptr_next = ptr_reg + ADDR_W'(1);
            if (ptr_reg == ADDR_W'(DEPTH - 1))
                state_next = RUN;
        end
    end

    // Single write port shared by the clear engine and write-back so the array maps to RAM.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wb_addr;
        mem_wdata = wb_data;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_reg;
            mem_wdata = '0;
        end else if (wb_en && wb_addr != '0) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Pending-write counters; entry 0 is hardwired to zero.
    logic [CNT_W-1:0] cnt [DEPTH];
    logic             issue_ok;

    assign iss_full = run && (cnt[iss_addr] == CNT_MAX);
    assign issue_ok = run && iss_en && !iss_full;
    assign cnt[0]   = '0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             iss_hit;
            logic             wb_hit;

            assign iss_hit = issue_ok && (iss_addr == ADDR_W'(gi));
            assign wb_hit  = run && wb_en && (wb_addr == ADDR_W'(gi));

            always_ff @(posedge clk) begin
                if (reset || (run && flush))
                    cnt_reg <= '0;
                else if (iss_hit && !wb_hit)
                    cnt_reg <= cnt_reg + CNT_W'(1);
                else if (wb_hit && !iss_hit && cnt_reg != '0)
                    cnt_reg <= cnt_reg - CNT_W'(1);
            end

            assign cnt[gi] = cnt_reg;
        end
    endgenerate

    // Read ports: the last outstanding write is forwarded, so it does not count as busy.
    logic [ADDR_W-1:0] ra_arr   [2];
    logic [DATA_W-1:0] rd_arr   [2];
    logic              busy_arr [2];

    assign ra_arr[0] = ra1;
    assign ra_arr[1] = ra2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            logic             bypass;
            logic [CNT_W-1:0] cnt_rd;

            assign bypass = wb_en && (wb_addr == ra_arr[gi]);
            assign cnt_rd = cnt[ra_arr[gi]];

            assign rd_arr[gi] = (!run || ra_arr[gi] == '0) ? '0 :
                                bypass ? wb_data : mem[ra_arr[gi]];
            assign busy_arr[gi] = run && (cnt_rd != '0) &&
                                  !(bypass && cnt_rd == CNT_W'(1));
        end
    endgenerate

    assign rd1   = rd_arr[0];
    assign rd2   = rd_arr[1];
    assign busy1 = busy_arr[0];
    assign busy2 = busy_arr[1];

`ifdef GRF_SB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && run && wb_en)
            $display("@%h: $%d <= %h", wb_pc, wb_addr, wb_data);
    end
`else
    logic unused_pc;
    assign unused_pc = ^wb_pc;
`endif

endmodule
